// File: rtl/adc_trig_capture_if.sv
// axis_if: AXI4-Stream data channel from the capture engine to its consumer.
interface axis_if #(parameter int DATA_WIDTH = 8);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: ring-buffer ADC capture around a trigger, drained as one AXI4-Stream frame.
module adc_trig_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic                  adc_clk,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  ext_trig,
    input  logic                  arm,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_level,
    input  logic [AW-1:0]         cfg_pre,
    input  logic [AW:0]           cfg_len,
    output logic                  busy,
    output logic                  triggered,
    axis_if.master                axis
);
    typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST, DRAIN} state_t;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t                state, state_n;
    logic                  adc_clk_q, strobe, pending, rise, fire, we, rd_en, load_out, done;
    logic [2:0]            trig_sync;
    logic [1:0]            mode_r;
    logic [DATA_WIDTH-1:0] level_r, prev, rd_data, tdata;
    logic [AW-1:0]         pre_r, pre_c, wr_ptr, trig_addr, rd_addr;
    logic [AW:0]           len_r, len_c, post_n, cnt;
    logic                  first, rd_valid, rd_last, tvalid, tlast;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign strobe = adc_clk & ~adc_clk_q;
    assign rise   = trig_sync[1] & ~trig_sync[2];
    assign len_c  = (cfg_len == '0 || cfg_len > FULL) ? FULL : cfg_len;
    assign pre_c  = ({1'b0, cfg_pre} >= len_c) ? AW'(len_c - 1'b1) : cfg_pre;
    assign post_n = len_r - {1'b0, pre_r} - 1'b1;
    // level modes compare against the previous sample written in this capture
    assign fire = mode_r == 2'd0 ? 1'b1 :
                  mode_r == 2'd3 ? pending :
                  mode_r == 2'd1 ? (!first && prev < level_r && adc_data >= level_r) :
                                   (!first && prev >= level_r && adc_data < level_r);
    assign we       = strobe && (state == PRE_FILL || state == WAIT_TRIG || state == POST);
    assign load_out = rd_valid && (!tvalid || axis.tready);
    assign rd_en    = state == DRAIN && cnt < len_r && (!rd_valid || load_out);
    assign rd_addr  = trig_addr - pre_r + cnt[AW-1:0];
    assign done     = tvalid && axis.tready && tlast;
    assign axis.tvalid = tvalid;
    assign axis.tdata  = tdata;
    assign axis.tlast  = tlast;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n   = state;
        busy      = state != IDLE;
        triggered = state == POST || state == DRAIN;
        case (state)
            IDLE:      if (arm) state_n = pre_c == '0 ? WAIT_TRIG : PRE_FILL;
            PRE_FILL:  if (strobe && cnt == {1'b0, pre_r} - 1'b1) state_n = WAIT_TRIG;
            WAIT_TRIG: if (strobe && fire) state_n = post_n == '0 ? DRAIN : POST;
            POST:      if (strobe && cnt == post_n - 1'b1) state_n = DRAIN;
            DRAIN:     if (done) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            adc_clk_q <= 1'b0;
            trig_sync <= '0;
            pending   <= 1'b0;
            mode_r    <= '0;
            level_r   <= '0;
            pre_r     <= '0;
            len_r     <= '0;
            cnt       <= '0;
            wr_ptr    <= '0;
            trig_addr <= '0;
            prev      <= '0;
            first     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            tvalid    <= 1'b0;
            tdata     <= '0;
            tlast     <= 1'b0;
        end else begin
            adc_clk_q <= adc_clk;
            trig_sync <= {trig_sync[1:0], ext_trig};
            pending   <= rise | (pending & ~strobe);
            if (state == IDLE && arm) begin
                mode_r  <= cfg_mode;
                level_r <= cfg_level;
                pre_r   <= pre_c;
                len_r   <= len_c;
                wr_ptr  <= '0;
                first   <= 1'b1;
            end
            if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                prev   <= adc_data;
                first  <= 1'b0;
            end
            if (state == WAIT_TRIG && strobe && fire) trig_addr <= wr_ptr;
            // one counter serves pre-fill, post-fill and drain issue, cleared on every transition
            if (state_n != state) cnt <= '0;
            else if (we || rd_en) cnt <= cnt + 1'b1;
            rd_valid <= rd_en | (rd_valid & ~load_out);
            if (rd_en) rd_last <= cnt == len_r - 1'b1;
            tvalid <= load_out | (tvalid & ~axis.tready);
            if (load_out) begin
                tdata <= rd_data;
                tlast <= rd_last;
            end else if (axis.tready) tlast <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (we) mem[wr_ptr] <= adc_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule
